exec_datapath: RTL and testbench
================================

// Module: exec_datapath
// PURPOSE
// - Single-cycle MIPS execute/memory/write-back slice: 32x32 register file, 4-bit-opcode ALU, word data memory.
// - Sits between decode (controller/extender) and fetch (branch flag); one instruction per clk.
// - Reads are combinational; register and memory writes commit on the rising clk edge.
// PARAMETERS
// - DM_AW   10  word-address width of data memory (DM depth = 2**DM_AW words = 1024)
// PORTS
// - clk        in   1   system clock, rising edge
// - reset      in   1   asynchronous, active-low; clears GRF and DM
// - a1         in   5   GRF read address 1 (rs)
// - a2         in   5   GRF read address 2 (rt)
// - a3         in   5   GRF write address
// - reg_write  in   1   GRF write enable
// - imm        in   32  extended immediate
// - alu_src    in   1   ALU operand B select: 0=rd2, 1=imm
// - alu_op     in   4   ALU operation code
// - mem_write  in   1   DM write enable
// - wb_sel     in   2   write-back select: 0=alu_result, 1=mem_out, 2=link, 3=alu_result
// - link       in   32  link value (PC+4/PC+8) for jal-type write-back
// - pc         in   32  current instruction PC (trace only)
// - rd1        out  32  GRF[a1]
// - rd2        out  32  GRF[a2]
// - alu_result out  32  ALU result; also the DM byte address
// - branch     out  1   1 when ALU operand A == operand B
// - mem_out    out  32  DM word at alu_result
// - wb_data    out  32  selected write-back data
// BEHAVIOUR
// - GRF: 32 regs; rd1/rd2 combinational; reg 0 always reads 0, writes to 0 discarded.
// - GRF write at posedge clk when reg_write=1 and a3!=0: GRF[a3] <= wb_data. No read bypass: same-cycle read returns old value.
// - ALU A = rd1; B = alu_src ? imm : rd2. Arithmetic mod 2^32, no overflow trap.
// - alu_op: 0 ADD, 1 SUB(A-B), 2 OR, 3 AND, 4 XOR, 5 NOR, 6 SLT signed (1/0), 7 SLTU,
//   8 LUI (B<<16), 9 SLL (B<<A[4:0]), 10 SRL, 11 SRA; 12-15 -> result 0.
// - branch = (A==B), independent of alu_op.
// - DM: 2**DM_AW x 32; word index = alu_result[DM_AW+1:2]; bits [1:0] and above DM_AW+1 ignored (wrap).
// - mem_out combinational; write at posedge clk when mem_write=1: DM[index] <= rd2. Read same cycle returns old word.
// - Reset (reset=0) asynchronously clears all GRF regs and DM words to 0; writes blocked while reset=0; outputs reflect cleared state combinationally.
// - reg_write and mem_write both high in one cycle: both commit in that same edge.
// CONFIGURATION
// - DATAPATH_TRACE_EN defined: at every committed write, $display
//   "@%h: $%d <= %h" (pc, a3, wb_data) for GRF; "@%h: *%h <= %h" (pc, alu_result&~3, rd2) for DM.
//   Writes to reg 0 are not printed.
// - Undefined: no display code; functional behaviour identical.
// TESTING
// - Reset: pulse reset=0 mid-run -> all rd1/rd2/mem_out read 0 immediately, next writes succeed after reset=1.
// - ADD imm: a1=0, imm=5, alu_src=1, alu_op=0, wb_sel=0, a3=8, reg_write=1 -> after edge GRF[8]=5.
// - Reg 0: a3=0, wb_data=0xFFFF -> GRF[0] still reads 0; same-cycle read of a3 target shows old value.
// - SUB/SLT: A=3, B=5 -> SUB 0xFFFFFFFE, SLT 1, SLTU 1; A=0xFFFFFFFF, B=1 -> SLT 1, SLTU 0; LUI imm=0x1234 -> 0x12340000.
// - Memory: store rd2=0xDEADBEEF at alu_result=0x10, load wb_sel=1 a3=9 -> GRF[9]=0xDEADBEEF; address 0x1010 aliases 0x10.
// - Branch/link: rd1=rd2=7 -> branch=1; wb_sel=2, link=0x3008, a3=31 -> GRF[31]=0x3008.

Source files
------------

// File: rtl/exec_datapath.sv
// -----------------------------------------------------------------------------
// exec_datapath
//
// Single-cycle MIPS execute / memory / write-back slice. One instruction per
// clock. Register file and data memory reads are combinational. Register and
// memory writes commit on the rising edge of clk.
//
// Parameters
//   DM_AW       word-address width of the data memory (depth = 2**DM_AW words)
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low; clears GRF and DM
//   a1          in   5   GRF read address 1 (rs)
//   a2          in   5   GRF read address 2 (rt)
//   a3          in   5   GRF write address
//   reg_write   in   1   GRF write enable
//   imm         in   32  extended immediate
//   alu_src     in   1   ALU operand B select: 0 = rd2, 1 = imm
//   alu_op      in   4   ALU operation code
//   mem_write   in   1   DM write enable
//   wb_sel      in   2   write-back select: 0 = alu, 1 = mem, 2 = link, 3 = alu
//   link        in   32  link value for jal-type write-back
//   pc          in   32  current instruction PC (used only by the write trace)
//   rd1         out  32  GRF[a1]
//   rd2         out  32  GRF[a2]
//   alu_result  out  32  ALU result; also the DM byte address
//   branch      out  1   1 when ALU operand A equals operand B
//   mem_out     out  32  DM word addressed by alu_result
//   wb_data     out  32  selected write-back data
//
// Optional feature
//   DATAPATH_TRACE_EN  when defined, every committed GRF / DM write prints one
//                      trace line. Undefined: no display code is compiled and
//                      behaviour is identical.
//
// There are no handshakes and no FSM in this block: every input is consumed
// in the cycle it is presented and every output is a pure function of the
// current inputs and stored state.
// -----------------------------------------------------------------------------
module exec_datapath #(
    parameter int DM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic        reg_write,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic [3:0]  alu_op,
    input  logic        mem_write,
    input  logic [1:0]  wb_sel,
    input  logic [31:0] link,
    input  logic [31:0] pc,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] alu_result,
    output logic        branch,
    output logic [31:0] mem_out,
    output logic [31:0] wb_data
);

    localparam int DM_DEPTH = 1 << DM_AW;

    // ALU operation codes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_LUI  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;

    // -------------------------------------------------------------------------
    // Internal signals
    // -------------------------------------------------------------------------
    logic [31:0]      grf_rd [0:31];         // read view of every GRF entry
    logic [31:0]      dm_rd  [0:DM_DEPTH-1]; // read view of every DM word
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [4:0]       shamt;
    logic [DM_AW-1:0] dm_idx;
    logic             grf_we_d;              // GRF write commits at next edge
    logic             dm_we_d;               // DM write commits at next edge

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    // Register 0 has no storage at all: it is a constant zero, so writes to it
    // vanish without needing a special case in the write path.
    assign grf_rd[0] = '0;

    assign grf_we_d = reg_write && (a3 != 5'd0);

    for (genvar g = 1; g < 32; g++) begin : g_grf
        logic [31:0] word_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_q <= '0;
            end else if (grf_we_d && (a3 == 5'(g))) begin
                word_q <= wb_data;
            end
        end

        assign grf_rd[g] = word_q;
    end

    // No write-to-read bypass: a read of the register being written this
    // cycle still returns the value stored before the edge.
    assign rd1 = grf_rd[a1];
    assign rd2 = grf_rd[a2];

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    assign op_a  = rd1;
    assign op_b  = alu_src ? imm : rd2;
    assign shamt = op_a[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_NOR:  alu_result = ~(op_a | op_b);
            OP_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            OP_SLTU: alu_result = (op_a < op_b) ? 32'd1 : 32'd0;
            OP_LUI:  alu_result = {op_b[15:0], 16'h0000};
            // Shifts take the value from B and the amount from A[4:0].
            OP_SLL:  alu_result = op_b << shamt;
            OP_SRL:  alu_result = op_b >> shamt;
            OP_SRA:  alu_result = 32'($signed(op_b) >>> shamt);
            default: alu_result = '0;   // codes 12..15 are undefined -> 0
        endcase
    end

    // Equality compare runs in parallel with the ALU so the branch decision
    // does not depend on which operation decode selected.
    assign branch = (op_a == op_b);

    // -------------------------------------------------------------------------
    // Data memory
    // -------------------------------------------------------------------------
    // Byte address -> word index. The two byte-offset bits and every bit above
    // the memory's reach are dropped, so higher addresses alias onto the array.
    assign dm_idx  = alu_result[DM_AW+1:2];
    assign dm_we_d = mem_write;

    for (genvar g = 0; g < DM_DEPTH; g++) begin : g_dm
        logic [31:0] word_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_q <= '0;
            end else if (dm_we_d && (dm_idx == DM_AW'(g))) begin
                word_q <= rd2;
            end
        end

        assign dm_rd[g] = word_q;
    end

    assign mem_out = dm_rd[dm_idx];

    // -------------------------------------------------------------------------
    // Write-back select
    // -------------------------------------------------------------------------
    always_comb begin
        wb_data = alu_result;
        case (wb_sel)
            2'd0:    wb_data = alu_result;
            2'd1:    wb_data = mem_out;
            2'd2:    wb_data = link;
            default: wb_data = alu_result;
        endcase
    end

    // -------------------------------------------------------------------------
    // Optional write trace
    // -------------------------------------------------------------------------
`ifdef DATAPATH_TRACE_EN
    // Only writes that actually commit are printed: nothing while reset is
    // held, and nothing for register 0.
    always_ff @(posedge clk) begin
        if (reset && grf_we_d) begin
            $display("@%h: $%d <= %h", pc, a3, wb_data);
        end
        if (reset && dm_we_d) begin
            $display("@%h: *%h <= %h", pc, alu_result & ~32'd3, rd2);
        end
    end

    // Address bits that never reach the memory index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{alu_result[31:DM_AW+2], alu_result[1:0]};
`else
    // pc only feeds the trace; the listed address bits never reach the index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc, alu_result[31:DM_AW+2], alu_result[1:0]};
`endif

endmodule

// File: tb/tb_exec_datapath.sv
// -----------------------------------------------------------------------------
// tb_exec_datapath
//
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge. Expected values are pushed into exp_q when stimulus is applied
// and popped when the corresponding output is observed.
// -----------------------------------------------------------------------------
module tb_exec_datapath;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2, a3;
  logic        reg_write;
  logic [31:0] imm;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        mem_write;
  logic [1:0]  wb_sel;
  logic [31:0] link;
  logic [31:0] pc;
  logic [31:0] rd1, rd2, alu_result, mem_out, wb_data;
  logic        branch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exec_datapath #(.DM_AW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .reg_write (reg_write),
    .imm       (imm),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .mem_write (mem_write),
    .wb_sel    (wb_sel),
    .link      (link),
    .pc        (pc),
    .rd1       (rd1),
    .rd2       (rd2),
    .alu_result(alu_result),
    .branch    (branch),
    .mem_out   (mem_out),
    .wb_data   (wb_data)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] model_grf [0:31];
  int          n_vec;
  int          n_miss;

  typedef struct {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        src;
    logic [31:0] im;
    logic [3:0]  op;
    logic [31:0] res;
  } alu_vec_t;

  alu_vec_t alu_tab [20];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    a1 = '0; a2 = '0; a3 = '0;
    reg_write = 1'b0; mem_write = 1'b0;
    imm = '0; alu_src = 1'b0; alu_op = '0;
    wb_sel = '0; link = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    pc = pc + 32'd4;
  endtask

  // Writes val into GRF[addr] via ADD $0 + imm.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] val);
    idle_inputs();
    a1 = 5'd0; alu_src = 1'b1; imm = val; alu_op = 4'd0;
    wb_sel = 2'd0; a3 = addr; reg_write = 1'b1;
    next_cycle();
    reg_write = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    a1 = 5'd17; a2 = 5'd31;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp_v) begin n_miss++; $display("FAIL reset_rd1: got %h expected %h", rd1, exp_v); end
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp_v) begin n_miss++; $display("FAIL reset_rd2: got %h expected %h", rd2, exp_v); end
    exp_v = exp_q.pop_front(); n_vec++;
    if (mem_out !== exp_v) begin n_miss++; $display("FAIL reset_mem: got %h expected %h", mem_out, exp_v); end
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_add_imm();
    idle_inputs();
    a1 = 5'd0; imm = 32'd5; alu_src = 1'b1; alu_op = 4'd0;
    wb_sel = 2'd0; a3 = 5'd8; reg_write = 1'b1;
    exp_q.push_back(32'd5);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (wb_data !== exp_v) begin n_miss++; $display("FAIL add_wb: got %h expected %h", wb_data, exp_v); end
    next_cycle();
    idle_inputs();
    a1 = 5'd8;
    exp_q.push_back(32'd5);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp_v) begin n_miss++; $display("FAIL add_grf8: got %h expected %h", rd1, exp_v); end
    next_cycle();
  endtask

  task automatic test_reg0();
    idle_inputs();
    a1 = 5'd0; imm = 32'h0000_FFFF; alu_src = 1'b1; a3 = 5'd0; reg_write = 1'b1;
    exp_q.push_back(32'h0000_FFFF);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (wb_data !== exp_v) begin n_miss++; $display("FAIL reg0_wb: got %h expected %h", wb_data, exp_v); end
    next_cycle();
    idle_inputs();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp_v) begin n_miss++; $display("FAIL reg0_rd1: got %h expected %h", rd1, exp_v); end
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp_v) begin n_miss++; $display("FAIL reg0_rd2: got %h expected %h", rd2, exp_v); end
    next_cycle();
    // Same-cycle read of the write target returns the old value.
    idle_inputs();
    a1 = 5'd0; imm = 32'h99; alu_src = 1'b1; a3 = 5'd8; reg_write = 1'b1; a2 = 5'd8;
    exp_q.push_back(32'd5);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp_v) begin n_miss++; $display("FAIL nobypass_old: got %h expected %h", rd2, exp_v); end
    next_cycle();
    reg_write = 1'b0;
    exp_q.push_back(32'h99);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp_v) begin n_miss++; $display("FAIL nobypass_new: got %h expected %h", rd2, exp_v); end
    next_cycle();
  endtask

  task automatic test_alu();
    write_reg(5'd1, 32'd3);
    write_reg(5'd2, 32'd5);
    write_reg(5'd3, 32'hFFFF_FFFF);
    write_reg(5'd4, 32'd1);
    //               ra     rb     src   imm            op      expected
    alu_tab[0]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd0,  32'd8};
    alu_tab[1]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd1,  32'hFFFF_FFFE};
    alu_tab[2]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd2,  32'd7};
    alu_tab[3]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd3,  32'd1};
    alu_tab[4]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd4,  32'd6};
    alu_tab[5]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd5,  32'hFFFF_FFF8};
    alu_tab[6]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd6,  32'd1};
    alu_tab[7]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd7,  32'd1};
    alu_tab[8]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd9,  32'h28};
    alu_tab[9]  = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd10, 32'd0};
    alu_tab[10] = '{5'd1, 5'd2, 1'b0, 32'h0,         4'd12, 32'd0};
    alu_tab[11] = '{5'd3, 5'd4, 1'b0, 32'h0,         4'd6,  32'd1};
    alu_tab[12] = '{5'd3, 5'd4, 1'b0, 32'h0,         4'd7,  32'd0};
    alu_tab[13] = '{5'd4, 5'd3, 1'b0, 32'h0,         4'd11, 32'hFFFF_FFFF};
    alu_tab[14] = '{5'd4, 5'd3, 1'b0, 32'h0,         4'd10, 32'h7FFF_FFFF};
    alu_tab[15] = '{5'd4, 5'd3, 1'b0, 32'h0,         4'd9,  32'hFFFF_FFFE};
    alu_tab[16] = '{5'd0, 5'd0, 1'b1, 32'h1234,      4'd8,  32'h1234_0000};
    alu_tab[17] = '{5'd2, 5'd1, 1'b0, 32'h0,         4'd6,  32'd0};
    alu_tab[18] = '{5'd1, 5'd0, 1'b1, 32'hFFFF_FFFF, 4'd0,  32'd2};
    alu_tab[19] = '{5'd2, 5'd1, 1'b0, 32'h0,         4'd15, 32'd0};
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      a1 = alu_tab[i].ra; a2 = alu_tab[i].rb; alu_src = alu_tab[i].src;
      imm = alu_tab[i].im; alu_op = alu_tab[i].op; wb_sel = 2'd3;
      exp_q.push_back(alu_tab[i].res);
      exp_q.push_back(alu_tab[i].res);
      @(negedge clk);
      exp_v = exp_q.pop_front(); n_vec++;
      if (alu_result !== exp_v) begin
        n_miss++; $display("FAIL alu[%0d] op=%0d: got %h expected %h", i, alu_op, alu_result, exp_v);
      end
      exp_v = exp_q.pop_front(); n_vec++;
      if (wb_data !== exp_v) begin
        n_miss++; $display("FAIL alu_wb3[%0d]: got %h expected %h", i, wb_data, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_memory();
    write_reg(5'd5, 32'hDEAD_BEEF);
    // Store: DM[0x10] <= GRF[5]; same-cycle read still returns the old word.
    idle_inputs();
    a1 = 5'd0; imm = 32'h10; alu_src = 1'b1; a2 = 5'd5; mem_write = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (mem_out !== exp_v) begin n_miss++; $display("FAIL store_old: got %h expected %h", mem_out, exp_v); end
    next_cycle();
    // Load into $9.
    idle_inputs();
    a1 = 5'd0; imm = 32'h10; alu_src = 1'b1; wb_sel = 2'd1; a3 = 5'd9; reg_write = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (wb_data !== exp_v) begin n_miss++; $display("FAIL load_wb: got %h expected %h", wb_data, exp_v); end
    next_cycle();
    idle_inputs();
    a1 = 5'd9;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp_v) begin n_miss++; $display("FAIL load_grf9: got %h expected %h", rd1, exp_v); end
    next_cycle();
    // Aliasing: upper bits and byte offset are ignored.
    begin
      logic [31:0] addrs [3];
      logic [31:0] exps  [3];
      addrs[0] = 32'h1010; exps[0] = 32'hDEAD_BEEF;
      addrs[1] = 32'h13;   exps[1] = 32'hDEAD_BEEF;
      addrs[2] = 32'h14;   exps[2] = 32'h0;
      for (int i = 0; i < 3; i++) begin
        idle_inputs();
        a1 = 5'd0; imm = addrs[i]; alu_src = 1'b1;
        exp_q.push_back(exps[i]);
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_vec++;
        if (mem_out !== exp_v) begin
          n_miss++; $display("FAIL alias[%h]: got %h expected %h", addrs[i], mem_out, exp_v);
        end
        next_cycle();
      end
    end
    // Register and memory write in the same edge.
    idle_inputs();
    a1 = 5'd0; imm = 32'h20; alu_src = 1'b1; a2 = 5'd5; mem_write = 1'b1;
    wb_sel = 2'd0; a3 = 5'd10; reg_write = 1'b1;
    next_cycle();
    idle_inputs();
    a1 = 5'd10;
    exp_q.push_back(32'h20);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp_v) begin n_miss++; $display("FAIL dual_grf: got %h expected %h", rd1, exp_v); end
    a1 = 5'd0; imm = 32'h20; alu_src = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (mem_out !== exp_v) begin n_miss++; $display("FAIL dual_dm: got %h expected %h", mem_out, exp_v); end
    next_cycle();
  endtask

  task automatic test_branch_link();
    write_reg(5'd6, 32'd7);
    write_reg(5'd7, 32'd7);
    idle_inputs();
    a1 = 5'd6; a2 = 5'd7; alu_op = 4'd4;
    exp_q.push_back(32'd1);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if ({31'd0, branch} !== exp_v) begin n_miss++; $display("FAIL branch_eq: got %b expected %h", branch, exp_v); end
    a2 = 5'd1;
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if ({31'd0, branch} !== exp_v) begin n_miss++; $display("FAIL branch_ne: got %b expected %h", branch, exp_v); end
    alu_src = 1'b1; imm = 32'd7;
    exp_q.push_back(32'd1);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if ({31'd0, branch} !== exp_v) begin n_miss++; $display("FAIL branch_imm: got %b expected %h", branch, exp_v); end
    next_cycle();
    idle_inputs();
    a1 = 5'd1; wb_sel = 2'd2; link = 32'h3008; a3 = 5'd31; reg_write = 1'b1;
    exp_q.push_back(32'h3008);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (wb_data !== exp_v) begin n_miss++; $display("FAIL link_wb: got %h expected %h", wb_data, exp_v); end
    next_cycle();
    idle_inputs();
    a1 = 5'd31;
    exp_q.push_back(32'h3008);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp_v) begin n_miss++; $display("FAIL link_grf31: got %h expected %h", rd1, exp_v); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  r;
    logic [31:0] v;
    model_grf[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      v = $urandom();
      model_grf[i] = v;
      write_reg(5'(i), v);
    end
    for (int i = 0; i < 30; i++) begin
      r = 5'($urandom_range(1, 31));
      v = $urandom();
      model_grf[r] = v;
      write_reg(r, v);
    end
    for (int i = 0; i < 32; i++) begin
      idle_inputs();
      a1 = 5'(i); a2 = 5'(31 - i);
      exp_q.push_back(model_grf[i]);
      exp_q.push_back(model_grf[31 - i]);
      @(negedge clk);
      exp_v = exp_q.pop_front(); n_vec++;
      if (rd1 !== exp_v) begin n_miss++; $display("FAIL b2b_rd1[%0d]: got %h expected %h", i, rd1, exp_v); end
      exp_v = exp_q.pop_front(); n_vec++;
      if (rd2 !== exp_v) begin n_miss++; $display("FAIL b2b_rd2[%0d]: got %h expected %h", 31 - i, rd2, exp_v); end
      next_cycle();
    end
  endtask

  task automatic test_reset_pulse();
    // GRF[9], GRF[10] and DM[0x10] all hold nonzero values here.
    idle_inputs();
    a1 = 5'd9; a2 = 5'd10; imm = 32'h10; alu_src = 1'b1;
    reset = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #2;
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp_v) begin n_miss++; $display("FAIL pulse_rd1: got %h expected %h", rd1, exp_v); end
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp_v) begin n_miss++; $display("FAIL pulse_rd2: got %h expected %h", rd2, exp_v); end
    exp_v = exp_q.pop_front(); n_vec++;
    if (mem_out !== exp_v) begin n_miss++; $display("FAIL pulse_mem: got %h expected %h", mem_out, exp_v); end
    // Writes are blocked while reset is held, even across a clock edge.
    idle_inputs();
    a1 = 5'd0; imm = 32'h77; alu_src = 1'b1; a3 = 5'd12; reg_write = 1'b1; a2 = 5'd12;
    @(posedge clk);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp_v) begin n_miss++; $display("FAIL pulse_blocked: got %h expected %h", rd2, exp_v); end
    reg_write = 1'b0;
    reset = 1'b1;
    next_cycle();
    write_reg(5'd12, 32'h55);
    idle_inputs();
    a2 = 5'd12;
    exp_q.push_back(32'h55);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp_v) begin n_miss++; $display("FAIL post_reset_grf: got %h expected %h", rd2, exp_v); end
    next_cycle();
    idle_inputs();
    a1 = 5'd0; imm = 32'h10; alu_src = 1'b1; a2 = 5'd12; mem_write = 1'b1;
    next_cycle();
    mem_write = 1'b0;
    exp_q.push_back(32'h55);
    @(negedge clk);
    exp_v = exp_q.pop_front(); n_vec++;
    if (mem_out !== exp_v) begin n_miss++; $display("FAIL post_reset_dm: got %h expected %h", mem_out, exp_v); end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_vec  = 0;
    n_miss = 0;
    pc     = 32'h0000_3000;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_add_imm();
    test_reg0();
    test_alu();
    test_memory();
    test_branch_link();
    test_back_to_back();
    test_reset_pulse();
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
